// File: rtl/strobe_decoder_4_16.sv
// Registered 4-to-16 one-hot strobe decoder with programmable hold and gap timing
// and a single-entry pending buffer behind a valid/ready handshake.
module strobe_decoder_4_16 #(
    parameter int unsigned HOLD_CYCLES = 32'd4,
    parameter int unsigned GAP_CYCLES  = 32'd1,
    parameter int unsigned CNT_W       = 32'd8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        en,
    input  logic        in_valid,
    input  logic [3:0]  in_idx,
    output logic        in_ready,
    output logic [15:0] y,
    output logic        out_valid,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 32'd1);
    localparam logic             GAP_EN    = (GAP_CYCLES != 32'd0);

    function automatic logic [15:0] decode_onehot(input logic [3:0] idx);
        decode_onehot = 16'h0001 << idx;
    endfunction

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [3:0]       act_idx_r, act_idx_s;
    logic [3:0]       pend_idx_r, pend_idx_s;
    logic             pend_full_r, pend_full_s;
    logic [15:0]      y_r;
    logic             out_valid_r;
    logic             busy_r;
    logic             xfer_s;
    logic             last_s;

    assign in_ready = en && !pend_full_r;
    assign xfer_s   = in_valid && in_ready;
    // Final cycle of a strobe+gap window: the next index is chosen here, not buffered
    assign last_s   = (cnt_r == CNT_ZERO) &&
                      ((state_r == ST_GAP) || ((state_r == ST_HOLD) && !GAP_EN));

    // Next state, down-counter, active index and pending buffer
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        act_idx_s   = act_idx_r;
        pend_full_s = pend_full_r;
        pend_idx_s  = pend_idx_r;
        if (!en) begin
            state_s     = ST_IDLE;
            cnt_s       = CNT_ZERO;
            pend_full_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (xfer_s) begin
                        act_idx_s = in_idx;
                        cnt_s     = HOLD_LOAD;
                        state_s   = ST_HOLD;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_HOLD, ST_GAP: begin
                    if (last_s) begin
                        // Pending entry wins; it and a live transfer are mutually exclusive
                        if (pend_full_r) begin
                            act_idx_s   = pend_idx_r;
                            pend_full_s = 1'b0;
                            cnt_s       = HOLD_LOAD;
                            state_s     = ST_HOLD;
                        end else if (xfer_s) begin
                            act_idx_s = in_idx;
                            cnt_s     = HOLD_LOAD;
                            state_s   = ST_HOLD;
                        end else begin
                            cnt_s   = CNT_ZERO;
                            state_s = ST_IDLE;
                        end
                    end else begin
                        if (cnt_r != CNT_ZERO) begin
                            cnt_s = cnt_r - CNT_ONE;
                        end else begin
                            cnt_s   = GAP_LOAD;
                            state_s = ST_GAP;
                        end
                        if (xfer_s) begin
                            pend_full_s = 1'b1;
                            pend_idx_s  = in_idx;
                        end else begin
                            pend_full_s = pend_full_r;
                        end
                    end
                end
                default: begin
                    state_s     = ST_IDLE;
                    cnt_s       = CNT_ZERO;
                    pend_full_s = 1'b0;
                end
            endcase
        end
    end

    // State register and outputs registered from the next-state values
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            act_idx_r   <= 4'h0;
            pend_idx_r  <= 4'h0;
            pend_full_r <= 1'b0;
            y_r         <= 16'h0000;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            act_idx_r   <= act_idx_s;
            pend_idx_r  <= pend_idx_s;
            pend_full_r <= pend_full_s;
            y_r         <= (state_s == ST_HOLD) ? decode_onehot(act_idx_s) : 16'h0000;
            out_valid_r <= (state_s == ST_HOLD);
            busy_r      <= (state_s != ST_IDLE) || pend_full_s;
        end
    end

    assign y         = y_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;

endmodule
